// File: rtl/beep_sequencer.sv
// Fixed-priority multi-channel speaker beeper: trigger edges queue beeps, played one at a time with a gap.
// Optional BEEP_PREEMPT_EN: a lower-index request aborts a tone in progress (never a gap).
//   state | meaning
//   IDLE  | nothing playing; grants lowest pending channel
//   TONE  | square wave for the latched duration
//   GAP   | silent spacing; done pulses on its last cycle
module beep_sequencer #(
    parameter int N_CH = 2,
    parameter int HALF_W = 16,
    parameter int DUR_W = 25,
    parameter int GAP_CYC = 1000000,
    parameter logic [N_CH-1:0] EDGE_MODE = N_CH'(2'b10),
    parameter int BOOT_BEEP = 1,
    localparam int CH_W = $clog2(N_CH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        trig,
    input  logic [N_CH*HALF_W-1:0] half_period,
    input  logic [N_CH*DUR_W-1:0]  duration,
    input  logic                   mute,
    output logic                   speaker,
    output logic                   busy,
    output logic [CH_W-1:0]        active_ch,
    output logic                   done
);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    logic              rst_meta;
    logic              rst_sync_n;
    logic [N_CH-1:0]   trig_s1;
    logic [N_CH-1:0]   trig_s2;
    logic [N_CH-1:0]   trig_prev;
    logic [N_CH-1:0]   edge_q;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   grant_oh;
    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;
    logic [HALF_W-1:0] half_sel;
    logic [DUR_W-1:0]  dur_sel;
    logic              preempt;
    logic              do_grant;
    logic [HALF_W-1:0] half_lat;
    logic [HALF_W-1:0] half_cnt;
    logic [DUR_W-1:0]  dur_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              tone;

    // Reset asserts asynchronously but releases on the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            trig_s1   <= '0;
            trig_s2   <= '0;
            trig_prev <= '0;
            edge_q    <= '0;
        end else begin
            trig_s1   <= trig;
            trig_s2   <= trig_s1;
            trig_prev <= trig_s2;
            // Any-edge channels take both directions, the rest only rising.
            edge_q    <= (trig_s2 ^ trig_prev) & (EDGE_MODE | trig_s2);
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        half_sel    = '0;
        dur_sel     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(i);
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                half_sel    = half_period[i*HALF_W +: HALF_W];
                dur_sel     = duration[i*DUR_W +: DUR_W];
            end
        end
    end

`ifdef BEEP_PREEMPT_EN
    assign preempt = (state == TONE) && grant_found && (grant_idx < active_ch);
`else
    assign preempt = 1'b0;
`endif
    assign do_grant = ((state == IDLE) && grant_found) || preempt;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state     <= IDLE;
            pending   <= N_CH'(BOOT_BEEP != 0);
            active_ch <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            speaker   <= 1'b0;
            tone      <= 1'b0;
            half_lat  <= '0;
            half_cnt  <= '0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            pending <= (pending & ~(do_grant ? grant_oh : '0)) | edge_q;
            done    <= 1'b0;
            if (do_grant) begin
                active_ch <= grant_idx;
                half_lat  <= half_sel;
                half_cnt  <= (half_sel == '0) ? '0 : half_sel - HALF_W'(1);
                dur_cnt   <= dur_sel;
                tone      <= 1'b0;
                speaker   <= 1'b0;
                busy      <= 1'b1;
                if (dur_sel == '0) begin
                    state   <= GAP;
                    gap_cnt <= GAP_W'(GAP_CYC - 1);
                    done    <= (GAP_CYC == 1);
                end else begin
                    state <= TONE;
                end
            end else begin
                case (state)
                    TONE: begin
                        if (dur_cnt <= DUR_W'(1)) begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(GAP_CYC - 1);
                            done    <= (GAP_CYC == 1);
                            tone    <= 1'b0;
                            speaker <= 1'b0;
                        end else begin
                            dur_cnt <= dur_cnt - DUR_W'(1);
                            // A zero half-period holds the tone low for a silent beep.
                            if (half_lat != '0 && half_cnt == '0) begin
                                half_cnt <= half_lat - HALF_W'(1);
                                tone     <= ~tone;
                                speaker  <= ~tone & ~mute;
                            end else begin
                                if (half_lat != '0)
                                    half_cnt <= half_cnt - HALF_W'(1);
                                speaker <= tone & ~mute;
                            end
                        end
                    end
                    GAP: begin
                        speaker <= 1'b0;
                        if (gap_cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                            done    <= (gap_cnt == GAP_W'(1));
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        speaker <= 1'b0;
                        tone    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer: per-cycle behavioural model comparison plus directed literal checks.
module tb_beep_sequencer;
    localparam int N_CH = 2;
    localparam int HALF_W = 8;
    localparam int DUR_W = 10;
    localparam int GAP_CYC = 8;
    localparam int BOOT_BEEP = 1;
    localparam logic [1:0] EDGE_MODE = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  trig = 2'b00;
    logic [15:0] half_period;
    logic [19:0] duration;
    logic        mute = 1'b0;
    logic        speaker;
    logic        busy;
    logic [1:0]  active_ch;
    logic        done;

    int n_vec = 0;
    int n_bad = 0;
    int done_total = 0;
    int done_ch1 = 0;
    int done_seq = 0;

    beep_sequencer #(
        .N_CH(N_CH), .HALF_W(HALF_W), .DUR_W(DUR_W), .GAP_CYC(GAP_CYC),
        .EDGE_MODE(EDGE_MODE), .BOOT_BEEP(BOOT_BEEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .half_period(half_period),
        .duration(duration), .mute(mute), .speaker(speaker), .busy(busy),
        .active_ch(active_ch), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus elapsed cycles, speaker derived arithmetically.
    int       m_phase;   // 0 idle, 1 tone, 2 gap
    int       m_t, m_ch, m_h, m_d, m_rs;
    bit       m_mute_q;
    bit [1:0] m_pend;
    bit [1:0] m_hist [4];

    function automatic int lowest(input bit [1:0] p);
        for (int i = 0; i < N_CH; i++)
            if (p[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_t = 0; m_ch = 0; m_h = 0; m_d = 0; m_rs = 0;
        m_mute_q = 1'b0;
        m_pend = (BOOT_BEEP != 0) ? 2'b01 : 2'b00;
        for (int i = 0; i < 4; i++) m_hist[i] = 2'b00;
    endtask

    task automatic m_grant();
        int i;
        i = lowest(m_pend);
        m_pend[i] = 1'b0;
        m_ch = i;
        m_h = int'(half_period[i*HALF_W +: HALF_W]);
        m_d = int'(duration[i*DUR_W +: DUR_W]);
        m_t = 0;
        m_phase = (m_d == 0) ? 2 : 1;
    endtask

    task automatic m_step();
        bit [1:0] set;
        bit       preempted;
        if (m_rs < 2) begin
            m_rs++;
            return;
        end
        // A trigger sample taken at edge k reaches pending at edge k+3.
        for (int i = 0; i < N_CH; i++) begin
            if (EDGE_MODE[i]) set[i] = m_hist[2][i] != m_hist[3][i];
            else              set[i] = m_hist[2][i] && !m_hist[3][i];
        end
        m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = trig;
        preempted = 1'b0;
        case (m_phase)
            0: if (m_pend != 0) m_grant();
            1: begin
`ifdef BEEP_PREEMPT_EN
                if (m_pend != 0 && lowest(m_pend) < m_ch) begin
                    m_grant();
                    preempted = 1'b1;
                end
`endif
                if (!preempted) begin
                    m_t++;
                    if (m_t == m_d) begin m_phase = 2; m_t = 0; end
                end
            end
            default: begin
                m_t++;
                if (m_t == GAP_CYC) begin m_phase = 0; m_t = 0; end
            end
        endcase
        m_pend |= set;
        m_mute_q = mute;
    endtask

    initial begin
        bit e_spk;
        m_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) m_reset(); else m_step();
            @(negedge clk);
            if (!rst_n) m_reset();
            e_spk = (m_phase == 1) && (m_h > 0) && (((m_t / (m_h > 0 ? m_h : 1)) % 2) == 1) && !m_mute_q;
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("speaker", int'(speaker), int'(e_spk));
            chk("done", int'(done), int'(m_phase == 2 && m_t == GAP_CYC - 1));
            if (busy || !rst_n) chk("active_ch", int'(active_ch), m_ch);
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_total++;
            if (active_ch == 2'd1) done_ch1++;
            done_seq = done_seq * 10 + int'(active_ch) + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic window(input int n, output int b, output int r, output int first);
        logic prev;
        prev = speaker; b = 0; r = 0; first = -1;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (busy) begin
                b++;
                if (first < 0) first = k;
            end
            if (speaker && !prev) r++;
            prev = speaker;
        end
    endtask

    initial begin
        int b, r, first, d0, c0, lat;
        bit found;
        half_period = {8'd5, 8'd4};
        duration    = {10'd20, 10'd40};
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_speaker", int'(speaker), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_active_ch", int'(active_ch), 0);

        // Boot beep on channel 0
        rst_n = 1'b1;
        d0 = done_total;
        window(80, b, r, first);
        chk("boot_first_busy", first, 3);
        chk("boot_busy_cycles", b, 48);
        chk("boot_rises", r, 5);
        chk("boot_done", done_total - d0, 1);

        // Simultaneous rises served in index order
        half_period = {8'd5, 8'd3};
        duration    = {10'd20, 10'd12};
        d0 = done_total; done_seq = 0;
        trig = 2'b11;
        window(100, b, r, first);
        chk("simul_busy_cycles", b, 48);
        chk("simul_done", done_total - d0, 2);
        chk("simul_order", done_seq, 12);

        // Falling edges: ch0 ignored, ch1 triggers
        trig = 2'b10;
        window(40, b, r, first);
        chk("fall_ch0_busy", b, 0);
        done_seq = 0;
        trig = 2'b00;
        window(60, b, r, first);
        chk("fall_ch1_busy", b, 28);
        chk("fall_ch1_seq", done_seq, 2);

        // Repeated edges during ch0 tone coalesce into one replay
        half_period = {8'd5, 8'd4};
        duration    = {10'd20, 10'd40};
        d0 = done_total;
        trig = 2'b01;
        for (int k = 0; k < 3; k++) begin
            repeat (6) tick();
            trig = 2'b00;
            repeat (4) tick();
            trig = 2'b01;
        end
        window(120, b, r, first);
        chk("coalesce_done", done_total - d0, 2);

        // Silent beep with zero half-period
        half_period[7:0] = 8'd0;
        duration[9:0]    = 10'd10;
        trig = 2'b00;
        repeat (5) tick();
        d0 = done_total;
        trig = 2'b01;
        window(40, b, r, first);
        chk("silent_rises", r, 0);
        chk("silent_busy", b, 18);
        chk("silent_done", done_total - d0, 1);

        // Mute mid-tone
        half_period[7:0] = 8'd2;
        duration[9:0]    = 10'd30;
        trig = 2'b00;
        repeat (5) tick();
        d0 = done_total;
        trig = 2'b01;
        repeat (12) tick();
        mute = 1'b1;
        window(60, b, r, first);
        mute = 1'b0;
        chk("mute_rises", r, 0);
        chk("mute_done", done_total - d0, 1);

        // Lower-index request arriving during a long ch1 tone
        half_period[15:8] = 8'd3;
        duration[19:10]   = 10'd100;
        trig = 2'b00;
        repeat (5) tick();
        trig = 2'b10;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (busy && active_ch == 2'd1) found = 1'b1;
        end
        chk("ch1_started", int'(found), 1);
        repeat (9) tick();
        d0 = done_total; c0 = done_ch1;
        trig = 2'b11;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (busy && active_ch == 2'd0 && lat < 0) lat = k;
        end
        window(200, b, r, first);
`ifdef BEEP_PREEMPT_EN
        chk("preempt_latency", lat, 5);
        chk("preempt_ch1_done", done_ch1 - c0, 0);
        chk("preempt_total_done", done_total - d0, 1);
`else
        chk("nopreempt_latency", lat, -1);
        chk("nopreempt_ch1_done", done_ch1 - c0, 1);
        chk("nopreempt_total_done", done_total - d0, 2);
`endif

        // Reset mid-tone
        trig = 2'b01;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (busy) found = 1'b1;
        end
        repeat (3) tick();
        chk("midrst_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        trig = 2'b00;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_speaker", int'(speaker), 0);
        chk("midrst_done", int'(done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        first = -1; lat = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (busy && first < 0) begin
                first = k;
                lat = int'(active_ch);
            end
        end
        chk("rerst_first_busy", first, 3);
        chk("rerst_active_ch", lat, 0);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                int idx;
                idx = int'($urandom_range(0, 1));
                trig[idx] = ~trig[idx];
            end
            if ($urandom_range(0, 29) == 0) mute = ~mute;
            if ($urandom_range(0, 9) == 0) begin
                half_period = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
                duration    = {10'($urandom_range(0, 30)), 10'($urandom_range(0, 30))};
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            tick();
        end
        mute = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
